// File: rtl/keccak_share_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : keccak_share_arbiter
// Purpose  : Round-robin session arbiter sharing one Keccak padder and
//            permutation core between two requesters (absorb, squeeze, release).
// Options  : KECCAK_ARB_TIMEOUT_EN adds an idle watchdog that revokes a stalled
//            session and reports it on arb_timeout / arb_timeout_id.
// Revision : 1.0 - initial release
// ============================================================================
module keccak_share_arbiter #(
    parameter int RATE_W      = 1344,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset_n,

    input  logic              r0_req,
    input  logic              r0_mode,
    input  logic [63:0]       r0_data,
    input  logic              r0_valid,
    input  logic              r0_last,
    input  logic [1:0]        r0_byte_num,
    output logic              r0_accept,
    output logic              r0_grant,
    output logic              r0_blk_valid,
    input  logic              r0_more,
    input  logic              r0_done,

    input  logic              r1_req,
    input  logic              r1_mode,
    input  logic [63:0]       r1_data,
    input  logic              r1_valid,
    input  logic              r1_last,
    input  logic [1:0]        r1_byte_num,
    output logic              r1_accept,
    output logic              r1_grant,
    output logic              r1_blk_valid,
    input  logic              r1_more,
    input  logic              r1_done,

    output logic [RATE_W-1:0] blk_data,

    output logic [63:0]       pad_in,
    output logic              pad_in_ready,
    output logic              pad_is_last,
    output logic              pad_mode,
    output logic [1:0]        pad_byte_num,
    input  logic              pad_buffer_full,

    output logic              core_clr,
    input  logic [RATE_W-1:0] core_out,
    input  logic              core_out_ready,
`ifdef KECCAK_ARB_TIMEOUT_EN
    output logic              arb_timeout,
    output logic              arb_timeout_id,
`endif
    output logic              core_squeeze
);

    typedef enum logic [2:0] {
        ST_CLEAR    = 3'd0,
        ST_IDLE     = 3'd1,
        ST_ABSORB   = 3'd2,
        ST_WAIT_OUT = 3'd3,
        ST_SQUEEZE  = 3'd4,
        ST_RELEASE  = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_owner;
    logic        r_last_owner;
    logic        r_mode;

    logic        w_req_any;
    logic        w_pick;
    logic        w_grant_now;
    logic        w_session;
    logic        w_in_absorb;
    logic        w_in_squeeze;
    logic        w_timeout;

    logic [63:0] w_own_data;
    logic        w_own_valid;
    logic        w_own_last;
    logic [1:0]  w_own_byte_num;
    logic        w_own_more;
    logic        w_own_done;

    // Everything the datapath sees from a requester goes through this
    // owner-selected mux, so the non-owner can never disturb the core.
    assign w_own_data     = r_owner ? r1_data     : r0_data;
    assign w_own_valid    = r_owner ? r1_valid    : r0_valid;
    assign w_own_last     = r_owner ? r1_last     : r0_last;
    assign w_own_byte_num = r_owner ? r1_byte_num : r0_byte_num;
    assign w_own_more     = r_owner ? r1_more     : r0_more;
    assign w_own_done     = r_owner ? r1_done     : r0_done;

    // Round robin: with both requesting, the one that did not own last wins.
    assign w_req_any   = r0_req | r1_req;
    assign w_pick      = r1_req & (~r0_req | ~r_last_owner);
    assign w_grant_now = (r_state == ST_IDLE) & w_req_any;

    assign w_in_absorb  = (r_state == ST_ABSORB);
    assign w_in_squeeze = (r_state == ST_SQUEEZE);
    assign w_session    = w_in_absorb | (r_state == ST_WAIT_OUT) | w_in_squeeze;

    assign r0_grant = w_session & ~r_owner;
    assign r1_grant = w_session &  r_owner;

    assign pad_in       = w_own_data;
    assign pad_byte_num = w_own_byte_num;
    assign pad_mode     = r_mode;
    assign pad_in_ready = w_in_absorb & w_own_valid & ~pad_buffer_full;
    assign pad_is_last  = pad_in_ready & w_own_last;

    assign r0_accept = pad_in_ready & ~r_owner;
    assign r1_accept = pad_in_ready &  r_owner;

    assign blk_data     = core_out;
    assign r0_blk_valid = w_in_squeeze & ~r_owner & core_out_ready;
    assign r1_blk_valid = w_in_squeeze &  r_owner & core_out_ready;

    assign core_clr = (r_state == ST_CLEAR);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_CLEAR;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b1;
            r_mode       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant_now) begin
                r_owner <= w_pick;
                r_mode  <= w_pick ? r1_mode : r0_mode;
            end
            if (r_state == ST_RELEASE) begin
                r_last_owner <= r_owner;
            end
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        core_squeeze = 1'b0;
        unique case (r_state)
            ST_CLEAR: begin
                w_state_nxt = ST_IDLE;
            end
            ST_IDLE: begin
                if (w_req_any) begin
                    w_state_nxt = ST_ABSORB;
                end
            end
            ST_ABSORB: begin
                if (w_timeout) begin
                    w_state_nxt = ST_RELEASE;
                end else if (pad_is_last) begin
                    w_state_nxt = ST_WAIT_OUT;
                end
            end
            ST_WAIT_OUT: begin
                if (core_out_ready) begin
                    w_state_nxt = ST_SQUEEZE;
                end
            end
            ST_SQUEEZE: begin
                // done outranks more: a finishing owner never costs a permutation
                if (w_own_done || w_timeout) begin
                    w_state_nxt = ST_RELEASE;
                end else if (w_own_more) begin
                    core_squeeze = 1'b1;
                    w_state_nxt  = ST_WAIT_OUT;
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_CLEAR;
            end
            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase
    end

`ifdef KECCAK_ARB_TIMEOUT_EN
    localparam int c_TO_W = $clog2(TIMEOUT_CYC + 1);

    logic [c_TO_W-1:0] r_to_cnt;
    logic              r_arb_timeout;
    logic              r_arb_timeout_id;
    logic              w_to_run;
    logic              w_to_kick;

    // Only owner-driven phases are watched; WAIT_OUT is the core's own latency.
    assign w_to_run  = w_in_absorb | w_in_squeeze;
    assign w_to_kick = pad_in_ready | (w_in_squeeze & (w_own_more | w_own_done));
    assign w_timeout = w_to_run & ~w_to_kick &
                       (r_to_cnt == c_TO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_cnt         <= '0;
            r_arb_timeout    <= 1'b0;
            r_arb_timeout_id <= 1'b0;
        end else begin
            if (!w_to_run || w_to_kick || w_timeout) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_grant_now) begin
                r_arb_timeout <= 1'b0;
            end else if (w_timeout) begin
                r_arb_timeout    <= 1'b1;
                r_arb_timeout_id <= r_owner;
            end
        end
    end

    assign arb_timeout    = r_arb_timeout;
    assign arb_timeout_id = r_arb_timeout_id;
`else
    logic w_unused_timeout;

    assign w_timeout        = 1'b0;
    assign w_unused_timeout = ^TIMEOUT_CYC;
`endif

endmodule
`default_nettype wire

// File: doc/keccak_share_arbiter.md
Name: keccak_share_arbiter

Overview:
- Shares one Keccak sponge (64-bit-word padder plus f_permutation core) between two requesters.
- Typical requesters: the SHAKE128 matrix-expansion sampler (requester 0) and the SHAKE256 hash/CRH unit (requester 1).
- Grants whole sessions (absorb, pad, squeeze one or more blocks, release) using round-robin priority.
- Multiplexes the absorb stream onto the padder, routes squeeze blocks back to the owner, and clears the core between sessions.

Parameters:
- RATE_W, 1344, width of squeeze block bus (the SHAKE128 rate; SHAKE256 uses the low 1088 bits)
- TIMEOUT_CYC, 1024, idle cycles before watchdog revoke (used only with the optional feature)

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- r0_req, r1_req  in  1 each  session request (level)
- r0_mode, r1_mode  in  1 each  0 = SHAKE128 (rate 1344), 1 = SHAKE256 (rate 1088)
- r0_data, r1_data  in  64 each  absorb word
- r0_valid, r1_valid  in  1 each  absorb word valid
- r0_last, r1_last  in  1 each  marks final absorb word
- r0_byte_num, r1_byte_num  in  2 each  valid-byte code of final word, passed through unmodified
- r0_accept, r1_accept  out  1 each  word consumed this cycle
- r0_grant, r1_grant  out  1 each  session owner
- r0_blk_valid, r1_blk_valid  out  1 each  squeeze block present on blk_data
- r0_more, r1_more  in  1 each  request the next squeeze block (pulse)
- r0_done, r1_done  in  1 each  end session (pulse)
- blk_data  out  RATE_W  squeeze block (shared bus, qualified by rN_blk_valid)
- pad_in  out  64  to padder
- pad_in_ready  out  1  to padder
- pad_is_last  out  1  to padder
- pad_mode  out  1  to padder
- pad_byte_num  out  2  to padder
- pad_buffer_full  in  1  from padder
- core_clr  out  1  synchronous active-high clear to padder and permutation
- core_out  in  RATE_W  from permutation
- core_out_ready  in  1  permutation result valid (level until squeeze)
- core_squeeze  out  1  pulse: permute again for the next block

Behaviour:
- Reset (reset_n low, async): state = CLEAR; all grants, accepts and blk_valids 0; pad_in_ready 0; core_clr 1; last-owner pointer = 1, so requester 0 wins first.
- CLEAR: core_clr = 1 for exactly 1 cycle, then go to IDLE.
- IDLE: wait for any rN_req.
  - Single request: grant it.
  - Both requests: grant the requester that is not the last owner.
  - Grant registers on the clock edge; rN_grant rises 1 cycle after req is sampled. The owner's mode is latched; pad_mode is held from the latched value for the whole session. Go to ABSORB.
- ABSORB:
  - pad_in = owner data; pad_byte_num = owner byte_num.
  - pad_in_ready = owner valid & ~pad_buffer_full.
  - pad_is_last = owner last & owner valid & ~pad_buffer_full.
  - rN_accept = pad_in_ready for the owner only; the non-owner's accept is always 0.
  - On an accepted word with last = 1, go to WAIT_OUT. pad_in_ready is held 0 from then on.
- WAIT_OUT: wait for core_out_ready, then go to SQUEEZE.
- SQUEEZE:
  - blk_data = core_out; owner blk_valid = core_out_ready.
  - Owner more: pulse core_squeeze 1 cycle, then go to WAIT_OUT.
  - Owner done: go to RELEASE.
  - more and done in the same cycle: done wins; no squeeze pulse.
- RELEASE: drop the grant, update the last-owner pointer, then go to CLEAR. Minimum session-to-session gap is 3 cycles (RELEASE, CLEAR, IDLE).
- Owner drops req mid-session: ignored. Only done ends a session.
- more/done outside SQUEEZE, or from the non-owner: ignored.
- pad_buffer_full high: absorb stalls; the owner's valid is held by the requester.
- Outputs are combinational from registered state plus the owner's inputs. There is no combinational path from a non-owner's inputs.

Optional Feature:
- KECCAK_ARB_TIMEOUT_EN defined: a counter runs in ABSORB and SQUEEZE.
  - Reset to 0 on any accepted word, more, or done.
  - On reaching TIMEOUT_CYC: force RELEASE, and raise sticky output arb_timeout (1 bit, owner-indexed as arb_timeout_id, 1 bit) until the next grant.
- Undefined: no counter and no arb_timeout ports; sessions never end except by done.

Test Plan:
- r0 requests mode 0, sends 3 words (last on word 3, byte_num = 2'd3), core_out_ready rises → pad_in matches all 3 words in order; pad_is_last high only with word 3; r0_blk_valid = 1; r0 done → core_clr pulses once, grant drops.
- r0 and r1 request in the same cycle after reset → r0 granted first; after r0 done, r1 granted 3 cycles after RELEASE; pad_mode = 1 throughout r1's session.
- pad_buffer_full held for 5 cycles mid-absorb → pad_in_ready and r0_accept are 0 for those 5 cycles; no word lost or duplicated.
- Owner in SQUEEZE pulses more twice → two core_squeeze pulses; blk_valid drops between blocks until core_out_ready returns.
- Non-owner r1_valid/r1_done asserted while r0 absorbs → no effect on pad_* signals or state; r1_accept stays 0.
- reset_n pulsed low during ABSORB → grants and accepts 0 immediately (async); core_clr high; after release, re-arbitration starts with r0 priority.
